// File: rtl/nios2_ocimem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// nios2_ocimem_arbiter_pkg : shared types and jdo field positions
// Rev 1.0
// ============================================================================
package nios2_ocimem_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int JDO_W          = 38;
  localparam int ADDR_LSB       = 2;
  localparam int DATA_LSB       = 3;
  localparam int RD_FLAG        = 35;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRD  = 2'd1,
    ST_JRD  = 2'd2
  } state_e;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/nios2_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// nios2_ocimem_arbiter : shares the OCI debug RAM between the CPU and JTAG
// Rev 1.0
// ============================================================================
module nios2_ocimem_arbiter
  import nios2_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
  logic [DATA_W-1:0]   mondreg_q, mondreg_d;
  logic                rd_pend_q, rd_pend_d;
  logic                wr_pend_q, wr_pend_d;
  logic                last_grant_q, last_grant_d;
  logic                mon_ready_q, mon_ready_d;
  logic                overrun_q, overrun_d;

  logic w_cpu_req;
  logic w_jtag_req;
  logic w_pulse;
  logic w_accept;
  logic w_unused_jdo;

  assign w_cpu_req  = cpu_read | cpu_write;
  assign w_jtag_req = rd_pend_q | wr_pend_q;
  assign w_pulse    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // A pending JTAG op or a read still landing in MonDReg blocks new commands.
  assign w_accept   = w_pulse & ~rd_pend_q & ~wr_pend_q & (state_q != ST_JRD);
  assign w_unused_jdo = ^{jdo[JDO_W-1:RD_FLAG+1], jdo[ADDR_LSB-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      jtag_addr_q  <= '0;
      mondreg_q    <= '0;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      last_grant_q <= GRANT_JTAG;
      mon_ready_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      jtag_addr_q  <= jtag_addr_d;
      mondreg_q    <= mondreg_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      last_grant_q <= last_grant_d;
      mon_ready_q  <= mon_ready_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    jtag_addr_d     = jtag_addr_q;
    mondreg_d       = mondreg_q;
    rd_pend_d       = rd_pend_q;
    wr_pend_d       = wr_pend_q;
    last_grant_d    = last_grant_q;
    mon_ready_d     = mon_ready_q;
    overrun_d       = overrun_q;
    cpu_readdata    = '0;
    cpu_waitrequest = 1'b1;
    ram_addr        = '0;
    ram_wren        = 1'b0;
    ram_byteenable  = 4'h0;
    ram_wdata       = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_cpu_req && (!w_jtag_req || last_grant_q == GRANT_JTAG)) begin
          last_grant_d = GRANT_CPU;
          ram_addr     = cpu_address;
          if (cpu_write) begin
            ram_wren        = 1'b1;
            ram_wdata       = cpu_writedata;
            ram_byteenable  = cpu_byteenable;
            cpu_waitrequest = 1'b0;
          end else begin
            state_d = ST_CRD;
          end
        end else if (w_jtag_req) begin
          last_grant_d = GRANT_JTAG;
          ram_addr     = jtag_addr_q;
          if (wr_pend_q) begin
            ram_wren       = 1'b1;
            ram_wdata      = mondreg_q;
            ram_byteenable = 4'hF;
            wr_pend_d      = 1'b0;
            jtag_addr_d    = jtag_addr_q + ADDR_ONE;
          end else begin
            rd_pend_d = 1'b0;
            state_d   = ST_JRD;
          end
        end
      end
      ST_CRD: begin
        cpu_readdata    = ram_rdata;
        cpu_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      ST_JRD: begin
        mondreg_d   = ram_rdata;
        jtag_addr_d = jtag_addr_q + ADDR_ONE;
        mon_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_pulse) begin
      mon_ready_d = 1'b0;
      if (!w_accept) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        jtag_addr_d = jdo[ADDR_LSB +: ADDR_W];
        if (jdo[RD_FLAG]) rd_pend_d = 1'b1;
      end else if (take_no_action_ocimem_a) begin
        rd_pend_d = 1'b1;
      end else begin
        mondreg_d = jdo[DATA_LSB +: DATA_W];
        wr_pend_d = 1'b1;
      end
    end
  end

  assign MonDReg       = mondreg_q;
  assign monitor_ready = mon_ready_q;
  assign jtag_overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2_ocimem_arbiter.sv
`default_nettype none
// Directed bench for nios2_ocimem_arbiter with a 256x32 registered-read RAM model.
module tb_nios2_ocimem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  logic [31:0] mem [0:255];
  int n_vec;
  int n_err;

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteenable(ram_byteenable),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] v;
    v = '0;
    v[9:2] = a;
    v[35]  = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'hCAFEF00D;
    mem[8'h21] = 32'h0BADBEEF;
    mem[8'h30] = 32'h55AA00FF;
    ram_rdata = '0;
    jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_wait", cpu_waitrequest, 1);
    chk("rst_wren", ram_wren, 0);
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_mready", monitor_ready, 0);
    chk("rst_overrun", jtag_overrun, 0);
    step(); step();
    reset_n = 1'b1;

    // CPU write then read back
    cpu_write = 1; cpu_address = 8'h10; cpu_writedata = 32'h12345678; cpu_byteenable = 4'hF;
    #1;
    chk("cw_wren", ram_wren, 1);
    chk("cw_addr", ram_addr, 8'h10);
    chk("cw_wdata", ram_wdata, 32'h12345678);
    chk("cw_be", ram_byteenable, 4'hF);
    chk("cw_wait", cpu_waitrequest, 0);
    step();
    cpu_write = 0; cpu_read = 1;
    #1;
    chk("cr_wait1", cpu_waitrequest, 1);
    chk("cr_addr", ram_addr, 8'h10);
    chk("cr_wren", ram_wren, 0);
    step();
    chk("cr_wait2", cpu_waitrequest, 0);
    chk("cr_data", cpu_readdata, 32'h12345678);
    step();
    cpu_read = 0;

    // JTAG address load with read
    jdo = jdo_addr(8'h20, 1'b1); take_action_ocimem_a = 1;
    step();
    take_action_ocimem_a = 0;
    #1;
    chk("jr_addr", ram_addr, 8'h20);
    chk("jr_wait", cpu_waitrequest, 1);
    step(); step();
    chk("jr_mondreg", MonDReg, 32'hCAFEF00D);
    chk("jr_mready", monitor_ready, 1);
    take_no_action_ocimem_a = 1;
    step();
    take_no_action_ocimem_a = 0;
    chk("jr2_mready_clr", monitor_ready, 0);
    #1;
    chk("jr2_addr_inc", ram_addr, 8'h21);
    step(); step();
    chk("jr2_mondreg", MonDReg, 32'h0BADBEEF);
    chk("jr2_mready", monitor_ready, 1);

    // Contention after reset: CPU first, then JTAG first
    reset_n = 0;
    step();
    reset_n = 1;
    jdo = jdo_data(32'hA5A55A5A); take_action_ocimem_b = 1;
    step();
    take_action_ocimem_b = 0;
    chk("c1_mondreg", MonDReg, 32'hA5A55A5A);
    cpu_read = 1; cpu_address = 8'h10;
    #1;
    chk("c1_cpu_first_addr", ram_addr, 8'h10);
    chk("c1_cpu_first_wren", ram_wren, 0);
    step();
    chk("c1_rdata", cpu_readdata, 32'h12345678);
    step();
    cpu_read = 0;
    #1;
    chk("c1_jw_wren", ram_wren, 1);
    chk("c1_jw_addr", ram_addr, 8'h00);
    chk("c1_jw_wdata", ram_wdata, 32'hA5A55A5A);
    chk("c1_jw_be", ram_byteenable, 4'hF);
    step();
    cpu_read = 1; cpu_address = 8'h00;
    jdo = jdo_data(32'h0F0F0F0F); take_action_ocimem_b = 1;
    #1;
    chk("c2_cpu_addr", ram_addr, 8'h00);
    step();
    take_action_ocimem_b = 0;
    chk("c2_rdata", cpu_readdata, 32'hA5A55A5A);
    step();
    cpu_address = 8'h10;
    #1;
    chk("c2_jtag_first_wren", ram_wren, 1);
    chk("c2_jtag_first_addr", ram_addr, 8'h01);
    chk("c2_jtag_first_wdata", ram_wdata, 32'h0F0F0F0F);
    chk("c2_jtag_first_wait", cpu_waitrequest, 1);
    step();
    chk("c2_cpu_next_addr", ram_addr, 8'h10);
    chk("c2_cpu_next_wren", ram_wren, 0);
    step();
    chk("c2_cpu_rdata", cpu_readdata, 32'h12345678);
    step();
    cpu_read = 0;

    // Address wrap from 0xFF
    jdo = jdo_addr(8'hFF, 1'b0); take_action_ocimem_a = 1;
    step();
    take_action_ocimem_a = 0;
    jdo = jdo_data(32'h11223344); take_action_ocimem_b = 1;
    step();
    take_action_ocimem_b = 0;
    #1;
    chk("wrap_wren", ram_wren, 1);
    chk("wrap_addr", ram_addr, 8'hFF);
    chk("wrap_wdata", ram_wdata, 32'h11223344);
    step();
    take_no_action_ocimem_a = 1;
    step();
    take_no_action_ocimem_a = 0;
    #1;
    chk("wrap_next_addr", ram_addr, 8'h00);
    step(); step();
    chk("wrap_mondreg", MonDReg, 32'hA5A55A5A);
    chk("wrap_mem_ff", mem[8'hFF], 32'h11223344);

    // Overrun while read pending, then reset inside CRD
    jdo = jdo_addr(8'h30, 1'b1); take_action_ocimem_a = 1;
    cpu_read = 1; cpu_address = 8'h10;
    #1;
    chk("ov_cpu_addr", ram_addr, 8'h10);
    step();
    take_action_ocimem_a = 0;
    chk("ov_none_yet", jtag_overrun, 0);
    take_no_action_ocimem_a = 1;
    #1;
    chk("ov_crd_rdata", cpu_readdata, 32'h12345678);
    step();
    take_no_action_ocimem_a = 0; cpu_read = 0;
    chk("ov_set", jtag_overrun, 1);
    #1;
    chk("ov_jr_addr", ram_addr, 8'h30);
    step(); step();
    chk("ov_mondreg", MonDReg, 32'h55AA00FF);
    chk("ov_mready", monitor_ready, 1);
    chk("ov_sticky", jtag_overrun, 1);
    cpu_read = 1; cpu_address = 8'h10;
    step();
    chk("mr_in_crd", cpu_waitrequest, 0);
    reset_n = 0;
    #1;
    chk("mr_wait", cpu_waitrequest, 1);
    chk("mr_rdata", cpu_readdata, 0);
    chk("mr_wren", ram_wren, 0);
    chk("mr_mondreg", MonDReg, 0);
    chk("mr_mready", monitor_ready, 0);
    chk("mr_overrun", jtag_overrun, 0);
    cpu_read = 0;
    step();
    reset_n = 1;
    #1;
    chk("mr_post_wren", ram_wren, 0);
    chk("mr_post_wait", cpu_waitrequest, 1);
    step();
    chk("mr_post2_wren", ram_wren, 0);
    chk("mr_post2_wait", cpu_waitrequest, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios2_ocimem_arbiter.md
NIOS2_OCIMEM_ARBITER -- requirements
Module: nios2_ocimem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, OCI memory word-address width (256 x 32 RAM).
REQ-002 Parameter DATA_W, default 32, data width; fixed at 32, other values unsupported.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 jdo  in  38  debug data word from the sysclk half of the debug slave.
REQ-006 take_action_ocimem_a  in  1  one-cycle pulse: load JTAG address, optional read.
REQ-007 take_no_action_ocimem_a  in  1  one-cycle pulse: read at current JTAG address.
REQ-008 take_action_ocimem_b  in  1  one-cycle pulse: write MonDReg data at current JTAG address.
REQ-009 cpu_address  in  ADDR_W; cpu_read, cpu_write  in  1; cpu_writedata  in  32; cpu_byteenable  in  4; Avalon-MM CPU debug port.
REQ-010 cpu_readdata  out  32; cpu_waitrequest  out  1.
REQ-011 ram_addr  out  ADDR_W; ram_wren  out  1; ram_byteenable  out  4; ram_wdata  out  32; ram_rdata  in  32 (one-cycle registered read latency).
REQ-012 MonDReg  out  32  JTAG data register; monitor_ready  out  1  JTAG read data valid; jtag_overrun  out  1  sticky error.

Function
REQ-013 take_action_ocimem_a SHALL load jtag_addr <= jdo[ADDR_W+1:2]; if jdo[35]=1 it SHALL also set jtag_rd_pend.
REQ-014 take_no_action_ocimem_a SHALL set jtag_rd_pend; take_action_ocimem_b SHALL load MonDReg <= jdo[34:3] and set jtag_wr_pend.
REQ-015 Any JTAG pulse arriving while jtag_rd_pend or jtag_wr_pend is set, or FSM in JRD, SHALL be ignored and SHALL set jtag_overrun (sticky).
REQ-016 FSM states: IDLE, CRD, JRD.
REQ-017 IDLE arbitration among {CPU request (cpu_read|cpu_write), JTAG pending}: alternating priority via last_grant bit; winner is the requester not granted last; sole requester wins.
REQ-018 CPU write grant (IDLE): ram_wren=1, ram_addr=cpu_address, ram_wdata=cpu_writedata, ram_byteenable=cpu_byteenable, cpu_waitrequest=0 same cycle; stay IDLE.
REQ-019 CPU read grant (IDLE): ram_addr=cpu_address, -> CRD; in CRD cpu_readdata=ram_rdata, cpu_waitrequest=0, -> IDLE (2-cycle latency).
REQ-020 JTAG write grant: ram_wren=1, ram_addr=jtag_addr, ram_wdata=MonDReg, ram_byteenable=4'hF; clear jtag_wr_pend; jtag_addr increments mod 2^ADDR_W.
REQ-021 JTAG read grant: ram_addr=jtag_addr, clear jtag_rd_pend, -> JRD; in JRD MonDReg <= ram_rdata, jtag_addr increments (wraps), monitor_ready <= 1, -> IDLE.
REQ-022 monitor_ready SHALL clear on any JTAG pulse; stays set otherwise.
REQ-023 cpu_waitrequest SHALL be 1 in every cycle not named in REQ-018/019; ram_wren SHALL be 0 except REQ-018/020 grant cycles.
REQ-024 cpu_read and cpu_write both high: treated as write. Simultaneous rd_pend and wr_pend impossible per REQ-015.
REQ-025 JTAG pulse coinciding with a JTAG grant cycle SHALL be treated as overrun (REQ-015).

Reset
REQ-026 reset_n low SHALL asynchronously force: FSM IDLE, jtag_addr 0, MonDReg 0, pend flags 0, last_grant=JTAG (CPU wins first contention), monitor_ready 0, jtag_overrun 0, cpu_waitrequest 1.
REQ-027 Reset mid-operation SHALL abandon the transaction; no ram_wren after reset release until a new grant.

Structure
REQ-028 Shared package holds state enum, jdo bit-position constants (ADDR_LSB=2, DATA_LSB=3, RD_FLAG=35), default ADDR_W.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 CPU write 0x12345678 to addr 0x10, then read -> waitrequest low 1 cycle after write, read returns 0x12345678 after 2 cycles.
REQ-031 take_action_ocimem_a with jdo addr 0x20, jdo[35]=1, RAM[0x20]=0xCAFEF00D -> MonDReg=0xCAFEF00D, monitor_ready=1, jtag_addr=0x21.
REQ-032 JTAG write pending + CPU read same cycle after reset -> CPU served first, JTAG write next IDLE cycle; repeat -> JTAG first.
REQ-033 jtag_addr=0xFF, take_action_ocimem_b -> write at 0xFF, jtag_addr wraps to 0x00.
REQ-034 Second JTAG pulse while read pending -> ignored, jtag_overrun=1 until reset; reset_n pulsed in CRD -> waitrequest=1, FSM IDLE, all outputs at REQ-026 values.
